simd_mac_pipe: RTL
==================

SIMD_MAC_PIPE -- requirements
Module: simd_mac_pipe

Parameters
REQ-001 The block SHALL provide parameter W, default 16: operand width; must be even and at least 4.
REQ-002 The block SHALL provide parameter G, default 8: guard-bit count for the full-width accumulator; must be even and at least 2.

Interface
REQ-003 The block SHALL provide `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL provide `stall`, input, 1 bit: when high, every pipeline register holds.
REQ-006 The block SHALL provide `in_valid`, input, 1 bit: qualifies `instruction`, `multiplier` and `multiplicand`.
REQ-007 The block SHALL provide `instruction`, input, 3 bits: the operation code.
REQ-008 The block SHALL provide `multiplier`, input, W bits: signed operand A.
REQ-009 The block SHALL provide `multiplicand`, input, W bits: signed operand B.
REQ-010 The block SHALL provide `result`, output, 2W bits: the accumulator value.
REQ-011 The block SHALL provide `protect`, output, G bits: the accumulator guard bits.
REQ-012 The block SHALL provide `out_valid`, output, 1 bit: high for one unstalled cycle per completed valid operation.
REQ-013 The block SHALL provide `sat_flag`, output, 1 bit: sticky flag recording that a saturation clamped a value.

Function
REQ-014 Opcodes SHALL be: 000/100 clear; 001 mul-full; 010 mac-full; 011 sat-full; 101 mul-split; 110 mac-split; 111 sat-split.
REQ-015 The pipeline SHALL be three stages: S1 registers the inputs; S2 registers the products; S3 updates {`protect`,`result`} and `out_valid`.
REQ-016 Latency SHALL be 3 unstalled cycles from the input edge to the result edge; throughput SHALL be one operation per cycle.
REQ-017 Back-to-back mac operations SHALL each accumulate onto the result of the immediately preceding operation, with no hazard bubble.
REQ-018 Full mode SHALL operate on a (2W+G)-bit signed accumulator {`protect`,`result`}.
  - mul: acc = sext(A*B).
  - mac: acc = acc + sext(A*B), wrapping modulo 2^(2W+G).
REQ-019 Split mode SHALL form two independent lanes, each a W-bit result half plus a G/2-bit protect half.
  - Hi lane: `result`[2W-1:W] with `protect`[G-1:G/2], operands A[W-1:W/2] x B[W-1:W/2].
  - Lo lane: `result`[W-1:0] with `protect`[G/2-1:0], operands A[W/2-1:0] x B[W/2-1:0].
  - No carry or borrow SHALL cross between the lanes.
REQ-020 Full-mode sat SHALL clamp the signed accumulator to the range [-2^(2W-1), 2^(2W-1)-1] and set `protect` to the sign extension of the clamped value.
REQ-021 Split-mode sat SHALL do the same per lane, clamping to [-2^(W-1), 2^(W-1)-1].
REQ-022 `sat_flag` SHALL be set by any sat whose clamp changes a value, and cleared only by clear or by reset.
REQ-023 Clear SHALL zero `result`, `protect` and `sat_flag`.
REQ-024 An input with `in_valid` low SHALL propagate as a bubble: the accumulator is unchanged and `out_valid` is 0 in S3.
REQ-025 While `stall` is high, all S1–S3 registers, `out_valid` and `sat_flag` SHALL hold; no operation is lost or duplicated.
REQ-026 If `stall` and `in_valid` are high in the same cycle, the input SHALL be ignored.
REQ-027 `out_valid` SHALL be 1 after every completed valid opcode, clear and sat included.

Reset
REQ-028 While `reset_n` is low, all pipeline registers, `result`, `protect`, `out_valid` and `sat_flag` SHALL be 0, regardless of `clk` or `stall`.
REQ-029 Operations in flight when reset is asserted SHALL be discarded.
REQ-030 The first valid input after reset deassertion SHALL complete 3 cycles later.

Verification (W=16, G=8)
REQ-031 Full mul: 001, A=0x0003, B=0xFFFE -> 3 cycles later `result`=0xFFFFFFFA, `protect`=0xFF, `out_valid`=1.
REQ-032 Full accumulate and saturate:
  - Stimulus: 001, then 010 three times back-to-back, all with A=B=0x7FFF, then 011.
  - Before the sat: `result`=0xFFFC0004, `protect`=0x00.
  - After the sat: `result`=0x7FFFFFFF, `protect`=0x00, `sat_flag`=1.
  - A following 000 clears `sat_flag`.
REQ-033 Split mul:
  - 101, A=0x807F, B=0x807F -> `result`=0x40003F01, `protect`=0x00.
  - 101, A=0xFF02, B=0x0103 -> `result`=0xFFFF0006, `protect`=0xF0.
REQ-034 Stall: hold `stall` high 2 cycles while two macs are in flight -> outputs frozen during the stall, results arrive 2 cycles late, and the sum equals the unstalled sum.
REQ-035 Bubble: a 010 / `in_valid`=0 / 010 sequence -> the accumulator sums only the two products, and `out_valid` pattern is 1,0,1.
REQ-036 Reset mid-operation: pulse `reset_n` low for half a cycle during a mac chain -> all outputs 0 immediately, and no stale `out_valid` afterwards.

Source files
------------

// File: rtl/simd_mac_pipe.sv
// Three-stage signed multiply-accumulate with a full (2W+G)-bit mode and a
// two-lane split mode that shares the same accumulator register.

module simd_mac_lane #(
   parameter int AW = 24,
   parameter int RW = 16
) (
   input  logic [1:0]    kind,
   input  logic [AW-1:0] acc,
   input  logic [AW-1:0] prod,
   output logic [AW-1:0] nxt,
   output logic          clamp
);
   localparam logic [AW-1:0] SAT_MAX = {{(AW-RW+1){1'b0}}, {(RW-1){1'b1}}};
   localparam logic [AW-1:0] SAT_MIN = ~SAT_MAX;

   // Out of range when the bits above the result sign are not all copies of it.
   logic ovf;
   assign ovf = ~((&acc[AW-1:RW-1]) | ~(|acc[AW-1:RW-1]));

   always_comb begin
      clamp = 1'b0;
      nxt   = '0;
      case (kind)
         2'b01: nxt = prod;
         2'b10: nxt = acc + prod;
         2'b11: begin
            clamp = ovf;
            nxt   = ovf ? (acc[AW-1] ? SAT_MIN : SAT_MAX) : acc;
         end
         default: nxt = '0;
      endcase
   end
endmodule

module simd_mac_pipe #(
   parameter int W = 16,
   parameter int G = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           stall,
   input  logic           in_valid,
   input  logic [2:0]     instruction,
   input  logic [W-1:0]   multiplier,
   input  logic [W-1:0]   multiplicand,
   output logic [2*W-1:0] result,
   output logic [G-1:0]   protect,
   output logic           out_valid,
   output logic           sat_flag
);
   localparam int STAGES = 3;
   localparam int HW     = W / 2;
   localparam int HG     = G / 2;
   localparam int FA     = 2*W + G;
   localparam int LA     = W + HG;

   typedef struct packed {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } s1_t;

   typedef struct packed {
      logic [2:0]          op;
      logic [2*W-1:0]      p_full;
      logic [1:0][W-1:0]   p_lane;
   } s2_t;

   logic [STAGES:1]   vld_pipe;
   s1_t               s1;
   s2_t               s2;
   logic [FA-1:0]     acc;

   logic [2*W-1:0]    p_full;
   logic [1:0][W-1:0] p_lane;

   // Operands are sign-extended to the product width so an unsigned
   // multiply yields the correct two's-complement low bits.
   assign p_full = {{W{s1.a[W-1]}}, s1.a} * {{W{s1.b[W-1]}}, s1.b};

   for (genvar i = 0; i < 2; i++) begin : g_mul
      logic [HW-1:0] la, lb;
      assign la        = s1.a[i*HW +: HW];
      assign lb        = s1.b[i*HW +: HW];
      assign p_lane[i] = {{HW{la[HW-1]}}, la} * {{HW{lb[HW-1]}}, lb};
   end

   logic [FA-1:0]      full_prod, full_nxt;
   logic               full_clamp;
   logic [1:0][LA-1:0] lane_acc, lane_prod, lane_nxt;
   logic [1:0]         lane_clamp;
   logic [FA-1:0]      split_nxt;

   assign full_prod = {{G{s2.p_full[2*W-1]}}, s2.p_full};

   simd_mac_lane #(.AW(FA), .RW(2*W)) u_full (
      .kind  (s2.op[1:0]),
      .acc   (acc),
      .prod  (full_prod),
      .nxt   (full_nxt),
      .clamp (full_clamp)
   );

   // Lane i owns result[i*W +: W] and protect[i*HG +: HG]; 1 is hi, 0 is lo.
   for (genvar i = 0; i < 2; i++) begin : g_lane
      assign lane_acc[i]  = {acc[2*W + i*HG +: HG], acc[i*W +: W]};
      assign lane_prod[i] = {{HG{s2.p_lane[i][W-1]}}, s2.p_lane[i]};

      simd_mac_lane #(.AW(LA), .RW(W)) u_lane (
         .kind  (s2.op[1:0]),
         .acc   (lane_acc[i]),
         .prod  (lane_prod[i]),
         .nxt   (lane_nxt[i]),
         .clamp (lane_clamp[i])
      );
   end

   assign split_nxt = {lane_nxt[1][LA-1:W], lane_nxt[0][LA-1:W],
                       lane_nxt[1][W-1:0],  lane_nxt[0][W-1:0]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         s1       <= '0;
         s2       <= '0;
      end else if (!stall) begin
         vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
         s1       <= '{op: instruction, a: multiplier, b: multiplicand};
         s2       <= '{op: s1.op, p_full: p_full, p_lane: p_lane};
      end
   end

   // The accumulator is only written here, so a mac in S3 always sees the
   // previous operation's result without forwarding.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc      <= '0;
         sat_flag <= 1'b0;
      end else if (!stall && vld_pipe[2]) begin
         if (s2.op[1:0] == 2'b00) begin
            acc      <= '0;
            sat_flag <= 1'b0;
         end else if (s2.op[2]) begin
            acc      <= split_nxt;
            sat_flag <= sat_flag | (|lane_clamp);
         end else begin
            acc      <= full_nxt;
            sat_flag <= sat_flag | full_clamp;
         end
      end
   end

   assign result    = acc[2*W-1:0];
   assign protect   = acc[FA-1:2*W];
   assign out_valid = vld_pipe[STAGES];
endmodule
